// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: sequencer for a row of NUM_PE convolution PEs.
// Loads each PE's FW x FW filter, then streams ifmap windows.
// Ports: clk, reset (async high); start/config in; weight buffer
// read port; ifmap source valid/ready; PE config/weight/ifmap
// drive; per-PE output-valid in; busy/done/err_cfg status.
module pe_seq_ctrl #(
  parameter  int DATA_WIDTH       = 16,
  parameter  int MAX_FILTER_WIDTH = 11,
  parameter  int NUM_PE           = 4,
  localparam int LOG_MFW = $clog2(MAX_FILTER_WIDTH),
  localparam int AW =
    $clog2(NUM_PE * MAX_FILTER_WIDTH * MAX_FILTER_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [LOG_MFW:0]      i_filter_width,
  input  logic [LOG_MFW:0]      i_stride,
  input  logic [15:0]           i_num_windows,
  output logic                  o_wbuf_rd_en,
  output logic [AW-1:0]         o_wbuf_addr,
  input  logic [DATA_WIDTH-1:0] i_wbuf_data,
  input  logic [DATA_WIDTH-1:0] i_ifmap_data,
  input  logic                  i_ifmap_valid,
  output logic                  o_ifmap_ready,
  output logic [NUM_PE-1:0]     o_pe_en,
  output logic [LOG_MFW:0]      o_filter_width,
  output logic [LOG_MFW:0]      o_stride,
  output logic [DATA_WIDTH-1:0] o_weight_data,
  output logic                  o_weight_valid,
  output logic [LOG_MFW:0]      o_wr_w_row_ptr,
  output logic [LOG_MFW:0]      o_wr_w_col_ptr,
  output logic [DATA_WIDTH-1:0] o_ifmap_data,
  output logic                  o_ifmap_valid,
  output logic                  o_reset_ifmap,
  input  logic [NUM_PE-1:0]     i_peout_valid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err_cfg
);

  localparam int FWW = LOG_MFW + 1;
  localparam int PW  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  localparam logic [FWW-1:0] MFW_F = FWW'(MAX_FILTER_WIDTH);
  localparam logic [AW-1:0]  ROW_A = AW'(MAX_FILTER_WIDTH);
  localparam logic [AW-1:0]  PE_A  =
    AW'(MAX_FILTER_WIDTH * MAX_FILTER_WIDTH);
  localparam logic [PW-1:0]  LAST_P = PW'(NUM_PE - 1);

  typedef enum logic [2:0] {
    IDLE, WLOAD, WDRAIN, STREAM, RSTIF, DONE
  } state_t;

  state_t              state;
  logic [15:0]         nw_q;
  logic [15:0]         win_cnt;
  logic [PW-1:0]       p_cnt;
  logic [FWW-1:0]      r_cnt;
  logic [FWW-1:0]      c_cnt;
  logic [AW-1:0]       row_base;
  logic [AW-1:0]       pe_base;
  logic                drain;
  logic                rd_v1;
  logic [PW-1:0]       p1;
  logic [FWW-1:0]      r1;
  logic [FWW-1:0]      c1;
  logic [NUM_PE-1:0]   wsel;
  logic [NUM_PE-1:0]   done_mask;

  logic                cfg_bad;
  logic                last_c;
  logic                last_r;
  logic                last_p;
  logic                all_done;
  logic [15:0]         win_nxt;

  assign cfg_bad = (i_filter_width == '0)
                 | (i_filter_width > MFW_F)
                 | (i_stride == '0)
                 | (i_stride > i_filter_width)
                 | (i_num_windows == 16'd0);

  assign last_c   = c_cnt == o_filter_width - FWW'(1);
  assign last_r   = r_cnt == o_filter_width - FWW'(1);
  assign last_p   = p_cnt == LAST_P;
  assign all_done = &(done_mask | i_peout_valid);
  assign win_nxt  = win_cnt + 16'd1;

  assign o_busy        = state != IDLE;
  assign o_done        = state == DONE;
  assign o_reset_ifmap = state == RSTIF;
  assign o_ifmap_ready = state == STREAM;
  assign o_ifmap_valid = i_ifmap_valid & o_ifmap_ready;
  assign o_ifmap_data  = i_ifmap_data;
  assign o_wbuf_rd_en  = state == WLOAD;
  assign o_wbuf_addr   =
    o_wbuf_rd_en ? row_base + AW'(c_cnt) : '0;
  // Outside STREAM only an in-flight weight write enables a PE.
  assign o_pe_en =
    o_ifmap_ready  ? '1 :
    o_weight_valid ? wsel : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      nw_q           <= '0;
      win_cnt        <= '0;
      p_cnt          <= '0;
      r_cnt          <= '0;
      c_cnt          <= '0;
      row_base       <= '0;
      pe_base        <= '0;
      drain          <= 1'b0;
      rd_v1          <= 1'b0;
      p1             <= '0;
      r1             <= '0;
      c1             <= '0;
      wsel           <= '0;
      done_mask      <= '0;
      o_filter_width <= '0;
      o_stride       <= '0;
      o_weight_data  <= '0;
      o_weight_valid <= 1'b0;
      o_wr_w_row_ptr <= '0;
      o_wr_w_col_ptr <= '0;
      o_err_cfg      <= 1'b0;
    end else begin
      o_err_cfg <= 1'b0;
      // Two-stage weight pipe: read tag, then data + tag out.
      rd_v1 <= o_wbuf_rd_en;
      p1    <= p_cnt;
      r1    <= r_cnt;
      c1    <= c_cnt;
      o_weight_valid <= rd_v1;
      if (rd_v1) begin
        o_weight_data  <= i_wbuf_data;
        o_wr_w_row_ptr <= r1;
        o_wr_w_col_ptr <= c1;
        wsel           <= NUM_PE'(1) << p1;
      end
      unique case (state)
        IDLE: begin
          if (i_start) begin
            if (cfg_bad) begin
              o_err_cfg <= 1'b1;
            end else begin
              o_filter_width <= i_filter_width;
              o_stride       <= i_stride;
              nw_q           <= i_num_windows;
              win_cnt        <= '0;
              p_cnt          <= '0;
              r_cnt          <= '0;
              c_cnt          <= '0;
              row_base       <= '0;
              pe_base        <= '0;
              done_mask      <= '0;
              state          <= WLOAD;
            end
          end
        end
        WLOAD: begin
          if (last_c) begin
            c_cnt <= '0;
            if (last_r) begin
              r_cnt <= '0;
              if (last_p) begin
                drain <= 1'b0;
                state <= WDRAIN;
              end else begin
                p_cnt    <= p_cnt + PW'(1);
                pe_base  <= pe_base + PE_A;
                row_base <= pe_base + PE_A;
              end
            end else begin
              r_cnt    <= r_cnt + FWW'(1);
              row_base <= row_base + ROW_A;
            end
          end else begin
            c_cnt <= c_cnt + FWW'(1);
          end
        end
        WDRAIN: begin
          drain <= 1'b1;
          if (drain) state <= STREAM;
        end
        STREAM: begin
          done_mask <= done_mask | i_peout_valid;
          if (all_done) state <= RSTIF;
        end
        RSTIF: begin
          done_mask <= '0;
          win_cnt   <= win_nxt;
          state     <= (win_nxt == nw_q) ? DONE : STREAM;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl: scoreboard bench for pe_seq_ctrl.
// Stimulus queues expected reads/writes/pulses; monitor pops them.
module tb_pe_seq_ctrl;

  localparam int FWW = 5;
  localparam int AW  = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic [4:0]  i_filter_width = '0;
  logic [4:0]  i_stride = '0;
  logic [15:0] i_num_windows = '0;
  logic        o_wbuf_rd_en;
  logic [8:0]  o_wbuf_addr;
  logic [15:0] i_wbuf_data;
  logic [15:0] i_ifmap_data = '0;
  logic        i_ifmap_valid = 1'b0;
  logic        o_ifmap_ready;
  logic [3:0]  o_pe_en;
  logic [4:0]  o_filter_width;
  logic [4:0]  o_stride;
  logic [15:0] o_weight_data;
  logic        o_weight_valid;
  logic [4:0]  o_wr_w_row_ptr;
  logic [4:0]  o_wr_w_col_ptr;
  logic [15:0] o_ifmap_data;
  logic        o_ifmap_valid;
  logic        o_reset_ifmap;
  logic [3:0]  i_peout_valid = '0;
  logic        o_busy;
  logic        o_done;
  logic        o_err_cfg;

  pe_seq_ctrl dut (
    .clk(clk), .reset(reset), .i_start(i_start),
    .i_filter_width(i_filter_width), .i_stride(i_stride),
    .i_num_windows(i_num_windows),
    .o_wbuf_rd_en(o_wbuf_rd_en), .o_wbuf_addr(o_wbuf_addr),
    .i_wbuf_data(i_wbuf_data),
    .i_ifmap_data(i_ifmap_data), .i_ifmap_valid(i_ifmap_valid),
    .o_ifmap_ready(o_ifmap_ready), .o_pe_en(o_pe_en),
    .o_filter_width(o_filter_width), .o_stride(o_stride),
    .o_weight_data(o_weight_data),
    .o_weight_valid(o_weight_valid),
    .o_wr_w_row_ptr(o_wr_w_row_ptr),
    .o_wr_w_col_ptr(o_wr_w_col_ptr),
    .o_ifmap_data(o_ifmap_data), .o_ifmap_valid(o_ifmap_valid),
    .o_reset_ifmap(o_reset_ifmap),
    .i_peout_valid(i_peout_valid),
    .o_busy(o_busy), .o_done(o_done), .o_err_cfg(o_err_cfg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    int          r;
    int          c;
    logic [3:0]  pe;
    int          cy;
  } w_t;

  typedef struct {
    logic [2:0] code;
    int         cy;
  } ev_t;

  int  exp_rd[$];
  w_t  exp_w[$];
  ev_t exp_ev[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  w_t  wm;
  ev_t em;

  // Weight buffer: word = 0x55 tag over address, 1-cycle latency.
  logic [15:0] wbuf_q = 16'hDEAD;
  assign i_wbuf_data = wbuf_q;
  always @(posedge clk)
    wbuf_q <= o_wbuf_rd_en ? {7'h55, o_wbuf_addr} : 16'hDEAD;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               n, a, e, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (o_wbuf_rd_en) begin
        if (exp_rd.size() == 0) chk("rd_unexp", o_wbuf_rd_en, 0);
        else chk("rd_addr", o_wbuf_addr, exp_rd.pop_front());
      end
      if (o_weight_valid) begin
        if (exp_w.size() == 0) begin
          chk("w_unexp", o_weight_valid, 0);
        end else begin
          wm = exp_w.pop_front();
          chk("w_data", o_weight_data, wm.d);
          chk("w_row", o_wr_w_row_ptr, wm.r);
          chk("w_col", o_wr_w_col_ptr, wm.c);
          chk("w_pe_en", o_pe_en, wm.pe);
          chk("w_cyc", cyc, wm.cy);
        end
      end
      if (o_err_cfg | o_reset_ifmap | o_done) begin
        if (exp_ev.size() == 0) begin
          chk("ev_unexp", {o_done, o_reset_ifmap, o_err_cfg}, 0);
        end else begin
          em = exp_ev.pop_front();
          chk("ev_code", {o_done, o_reset_ifmap, o_err_cfg},
              em.code);
          chk("ev_cyc", cyc, em.cy);
        end
      end
      if (o_ifmap_ready) chk("pe_en_stream", o_pe_en, 4'hF);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push_ev(input logic [2:0] code, input int cy);
    ev_t e;
    e.code = code;
    e.cy   = cy;
    exp_ev.push_back(e);
  endtask

  task automatic start(input int fw, input int st, input int nw,
                       input bit legal, output int s);
    w_t w;
    int a;
    int k;
    i_filter_width = FWW'(fw);
    i_stride       = FWW'(st);
    i_num_windows  = 16'(nw);
    s = cyc;
    if (legal) begin
      k = 0;
      for (int p = 0; p < 4; p++)
        for (int r = 0; r < fw; r++)
          for (int c = 0; c < fw; c++) begin
            a = p * 121 + r * 11 + c;
            exp_rd.push_back(a);
            w.d  = {7'h55, AW'(a)};
            w.r  = r;
            w.c  = c;
            w.pe = 4'(1 << p);
            w.cy = s + 3 + k;
            exp_w.push_back(w);
            k++;
          end
    end else begin
      push_ev(3'b001, s + 1);
    end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic zeros_chk(input string n);
    chk(n, {o_busy, o_done, o_err_cfg, o_wbuf_rd_en,
            o_wbuf_addr, o_weight_valid, o_weight_data,
            o_wr_w_row_ptr, o_wr_w_col_ptr, o_pe_en,
            o_reset_ifmap, o_ifmap_ready, o_ifmap_valid,
            o_filter_width, o_stride}, 0);
  endtask

  task automatic clear_sb();
    exp_rd.delete();
    exp_w.delete();
    exp_ev.delete();
  endtask

  task automatic one_window_run(input int fw);
    int s;
    int w0;
    start(fw, 1, 1, 1, s);
    w0 = s + 4 * fw * fw + 3;
    wait_until(w0);
    push_ev(3'b010, w0 + 1);
    push_ev(3'b100, w0 + 2);
    i_peout_valid = 4'hF;
    tick();
    i_peout_valid = 4'h0;
    tick();
    tick();
    chk("run_idle_busy", o_busy, 0);
    chk("run_cfg_fw", o_filter_width, fw);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete (cycle %0d)",
             cyc);
    $fatal(1);
  end

  initial begin
    int s;
    int w0;
    int wn;
    logic [3:0] pat;

    #2;
    zeros_chk("rst_outs");
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Rejected configurations.
    start(0, 1, 1, 0, s);
    chk("rej_fw0_busy", o_busy, 0);
    tick();
    start(3, 4, 1, 0, s);
    chk("rej_st_busy", o_busy, 0);
    tick();
    start(3, 1, 0, 0, s);
    chk("rej_nw0_busy", o_busy, 0);
    tick();
    start(12, 1, 1, 0, s);
    chk("rej_fw12_busy", o_busy, 0);
    tick();
    chk("rej_no_latch", o_filter_width, 0);

    // FW=3, two windows with staggered PE returns.
    start(3, 1, 2, 1, s);
    chk("busy_after_start", o_busy, 1);
    wait_until(s + 5);
    i_peout_valid = 4'hF;
    tick();
    i_peout_valid = 4'h0;
    w0 = s + 39;
    wait_until(w0 - 1);
    chk("rdy_pre_stream", o_ifmap_ready, 0);
    tick();
    for (int win = 0; win < 2; win++) begin
      wn = cyc;
      push_ev(3'b010, wn + 13);
      if (win == 1) push_ev(3'b100, wn + 14);
      for (int k = 0; k < 13; k++) begin
        pat = '0;
        if (k == 5)  pat[0] = 1'b1;
        if (k == 7)  pat[1] = 1'b1;
        if (k == 9)  pat[2] = 1'b1;
        if (k == 12) pat[3] = 1'b1;
        i_peout_valid = pat;
        i_ifmap_valid = (k % 2) == 1;
        i_ifmap_data  = 16'(16'h1000 + win * 16 + k);
        i_start       = (win == 0) && (k == 3);
        #1;
        chk("ifm_vld", o_ifmap_valid, (k % 2) == 1);
        if ((k % 2) == 1)
          chk("ifm_dat", o_ifmap_data, 16'h1000 + win * 16 + k);
        tick();
      end
      i_peout_valid = '0;
      i_start       = 1'b0;
      i_ifmap_valid = 1'b1;
      #1;
      chk("rdy_rstif", o_ifmap_ready, 0);
      chk("ifv_rstif", o_ifmap_valid, 0);
      i_ifmap_valid = 1'b0;
      tick();
    end
    tick();
    chk("main_idle", o_busy, 0);
    chk("main_fw", o_filter_width, 3);
    chk("main_st", o_stride, 1);

    // Final capture coincides with an accepted sample.
    start(1, 1, 2, 1, s);
    wait_until(s + 9);
    push_ev(3'b010, s + 10);
    i_peout_valid = 4'hF;
    i_ifmap_valid = 1'b1;
    i_ifmap_data  = 16'hBEEF;
    #1;
    chk("sim_ifv", o_ifmap_valid, 1);
    chk("sim_dat", o_ifmap_data, 16'hBEEF);
    tick();
    i_peout_valid = 4'h0;
    chk("sim_rdy_low", o_ifmap_ready, 0);
    chk("sim_ifv_low", o_ifmap_valid, 0);
    tick();
    chk("sim_rdy_back", o_ifmap_ready, 1);
    chk("sim_ifv_back", o_ifmap_valid, 1);
    push_ev(3'b010, cyc + 1);
    push_ev(3'b100, cyc + 2);
    i_peout_valid = 4'hF;
    i_ifmap_valid = 1'b0;
    tick();
    i_peout_valid = 4'h0;
    tick();
    tick();
    chk("sim_idle", o_busy, 0);

    // Largest filter: pointers and addresses at their limits.
    one_window_run(11);

    // Async reset during weight load, then a clean run.
    start(3, 1, 1, 1, s);
    wait_until(s + 20);
    #1;
    reset = 1'b1;
    #1;
    zeros_chk("rst_wload");
    clear_sb();
    tick();
    reset = 1'b0;
    tick();
    one_window_run(2);

    // Async reset while streaming with the maximum window count.
    start(2, 2, 65535, 1, s);
    wait_until(s + 22);
    chk("st_busy", o_busy, 1);
    chk("st_rdy", o_ifmap_ready, 1);
    #1;
    reset = 1'b1;
    #1;
    zeros_chk("rst_stream");
    clear_sb();
    tick();
    reset = 1'b0;
    tick();
    one_window_run(1);

    tick();
    chk("sb_rd_left", exp_rd.size(), 0);
    chk("sb_w_left", exp_w.size(), 0);
    chk("sb_ev_left", exp_ev.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
